// File: rtl/answer_bcd_conv.sv
// Purpose: capture calculator results on rising edges of valid and convert them to packed BCD (double-dabble).
// Latency: start seen at edge E0 -> out_valid high for one cycle after edge E_WIDTH; back-to-back conversions chain without gaps.
// Backpressure: none; one-deep pending buffer absorbs a result during conversion, further results are dropped and flagged via sticky overrun.
// Build option: define ANSWER_SIGNED_EN to treat answer as two's complement (magnitude to bcd, sign to neg).
module answer_bcd_conv #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [WIDTH-1:0]      answer,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overrun
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t            state, state_n;
  logic              valid_d;
  logic [WIDTH-1:0]  sreg;
  logic [BW-1:0]     acc;
  logic [IW-1:0]     iter;
  logic [WIDTH-1:0]  pend;
  logic              pend_v;
  logic [BW-1:0]     bcd_q;
  logic              out_valid_q;
  logic              overrun_q;

  logic              start;
  logic              done;
  logic              load_ans;
  logic              load_pend;
  logic              pend_store;
  logic              drop;
  logic              finish;
  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_sh;
  logic [WIDTH-1:0]  sreg_sh;
  logic [WIDTH-1:0]  ans_mag;

  // Magnitude of the incoming result; identity for unsigned operation.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
`ifdef ANSWER_SIGNED_EN
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
`else
    return v;
`endif
  endfunction

  assign start   = valid & ~valid_d;
  assign done    = (state == CONV) && (iter == IW'(WIDTH - 1));
  assign ans_mag = mag_of(answer);

  // Add-3 correction on every nibble >= 5, then shift {acc, sreg} left by one.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_sh  = {acc_adj[BW-2:0], sreg[WIDTH-1]};
    sreg_sh = {sreg[WIDTH-2:0], 1'b0};
  end

  // Next-state and control decode: loads, pending buffer, overrun, completion.
  always_comb begin
    state_n    = state;
    load_ans   = 1'b0;
    load_pend  = 1'b0;
    pend_store = 1'b0;
    drop       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_ans = 1'b1;
          state_n  = CONV;
        end
      end
      CONV: begin
        if (done) begin
          finish = 1'b1;
          if (pend_v) begin
            load_pend  = 1'b1;
            pend_store = start;
          end else if (start) begin
            load_ans = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (start) begin
          if (pend_v) begin
            drop = 1'b1;
          end else begin
            pend_store = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_d <= 1'b0;
    end else begin
      state   <= state_n;
      valid_d <= valid;
    end
  end

  // Conversion datapath: load a new operand or run one double-dabble iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      acc  <= '0;
      iter <= '0;
    end else if (load_pend) begin
      sreg <= pend;
      acc  <= '0;
      iter <= '0;
    end else if (load_ans) begin
      sreg <= ans_mag;
      acc  <= '0;
      iter <= '0;
    end else if (state == CONV) begin
      sreg <= sreg_sh;
      acc  <= acc_sh;
      iter <= iter + IW'(1);
    end
  end

  // One-deep pending buffer; a store on the same edge as a drain wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      if (pend_store) begin
        pend   <= ans_mag;
        pend_v <= 1'b1;
      end else if (load_pend) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Result registers, completion strobe and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= finish;
      if (finish) begin
        bcd_q <= acc_sh;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef ANSWER_SIGNED_EN
  logic sign_cur;
  logic pend_sign;
  logic neg_q;

  // Sign bit travels with its operand through the pending buffer to the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_cur  <= 1'b0;
      pend_sign <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      if (load_pend) begin
        sign_cur <= pend_sign;
      end else if (load_ans) begin
        sign_cur <= answer[WIDTH-1];
      end
      if (pend_store) begin
        pend_sign <= answer[WIDTH-1];
      end
      if (finish) begin
        neg_q <= sign_cur;
      end
    end
  end

  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

  assign busy      = (state == CONV);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_answer_bcd_conv.sv
module tb_answer_bcd_conv;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;
  localparam int LAT    = WIDTH;

  logic                clk;
  logic                rst;
  logic                valid;
  logic [WIDTH-1:0]    answer;
  logic                busy;
  logic                out_valid;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;
  logic                overrun;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    int                  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

`ifdef ANSWER_SIGNED_EN
  localparam logic              NEG_1023 = 1'b1;
  localparam logic [15:0]       BCD_1023 = 16'h0001;
  localparam logic              NEG_3F6  = 1'b1;
  localparam logic [15:0]       BCD_3F6  = 16'h0010;
`else
  localparam logic              NEG_1023 = 1'b0;
  localparam logic [15:0]       BCD_1023 = 16'h1023;
  localparam logic              NEG_3F6  = 1'b0;
  localparam logic [15:0]       BCD_3F6  = 16'h1014;
`endif

  answer_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .answer    (answer),
    .busy      (busy),
    .out_valid (out_valid),
    .bcd       (bcd),
    .neg       (neg),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every out_valid must match the oldest expected result and its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: bcd=%0h at cycle %0d with nothing expected", bcd, cyc);
        end else begin
          e = exp_q.pop_front();
          check("bcd", 32'(bcd), 32'(e.bcd));
          check("neg", 32'(neg), 32'(e.neg));
          check("out_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] b, input logic n, input int c);
    exp_t e;
    e.bcd = b;
    e.neg = n;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Called at a negedge: next posedge is E0; returns at the negedge after E0 with valid low.
  task automatic pulse(input logic [WIDTH-1:0] a, input logic [15:0] b, input logic n);
    valid  = 1'b1;
    answer = a;
    push_exp(b, n, cyc + 1 + LAT);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0;

  initial begin
    rst    = 1'b0;
    valid  = 1'b0;
    answer = '0;
    wait_cyc(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    rst = 1'b1;
    wait_cyc(2);

    // Abandoned conversion: reset at E5 must kill it with no strobe.
    valid  = 1'b1;
    answer = 10'd1023;
    @(negedge clk);
    valid = 1'b0;
    wait_cyc(5);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(12);

    // Full-scale value with busy profile.
    pulse(10'd1023, BCD_1023, NEG_1023);
    check("busy_e0", 32'(busy), 32'd1);
    wait_cyc(9);
    check("busy_e9", 32'(busy), 32'd1);
    wait_cyc(1);
    check("busy_e10", 32'(busy), 32'd0);
    check("strobe_e10", 32'(out_valid), 32'd1);
    wait_cyc(1);
    check("strobe_e11", 32'(out_valid), 32'd0);
    check("hold_bcd", 32'(bcd), 32'(BCD_1023));
    wait_cyc(3);

    // Zero and a mid-range value.
    pulse(10'd0, 16'h0000, 1'b0);
    wait_cyc(12);
    pulse(10'd509, 16'h0509, 1'b0);
    wait_cyc(12);

    // Level held high: single start, later answer changes ignored.
    valid  = 1'b1;
    answer = 10'd42;
    push_exp(16'h0042, 1'b0, cyc + 1 + LAT);
    @(negedge clk);
    answer = 10'd99;
    wait_cyc(5);
    valid = 1'b0;
    wait_cyc(14);

    // Start coinciding with the completion edge: loaded directly, no gap.
    pulse(10'd123, 16'h0123, 1'b0);
    c0 = cyc;
    wait_cyc(9);
    valid  = 1'b1;
    answer = 10'd456;
    push_exp(16'h0456, 1'b0, c0 + 2 * LAT);
    @(negedge clk);
    valid = 1'b0;
    check("chain_busy", 32'(busy), 32'd1);
    check("chain_overrun", 32'(overrun), 32'd0);
    wait_cyc(14);

    // Pending buffer and overrun: 7, then 300 buffered, 999 dropped.
    pulse(10'd7, 16'h0007, 1'b0);
    c0 = cyc;
    wait_cyc(2);
    valid  = 1'b1;
    answer = 10'd300;
    push_exp(16'h0300, 1'b0, c0 + 2 * LAT);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("ovr_before", 32'(overrun), 32'd0);
    valid  = 1'b1;
    answer = 10'd999;
    @(negedge clk);
    valid = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    wait_cyc(15);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("busy_after_pend", 32'(busy), 32'd0);
    wait_cyc(5);

    // Negative-looking input: sign handling depends on build option.
    pulse(10'h3F6, BCD_3F6, NEG_3F6);
    wait_cyc(14);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/answer_bcd_conv.md
Name: answer_bcd_conv

Overview:
Downstream result stage of the stack calculator. It captures `answer` on each new assertion of the calculator's `valid` (the "=" command). It converts the value to packed BCD digits with an iterative shift-add-3 (double-dabble) engine and presents the result with a one-cycle `out_valid` strobe for the display/readout logic. A one-deep pending buffer absorbs a second result that arrives during a conversion.

Parameters:
- WIDTH, 10, bit width of `answer`; also the number of conversion iterations.
- DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1. Not checked in RTL.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  result-ready level from the calculator; may stay high for several cycles.
- answer  input  WIDTH  calculator result; sampled only on a detected rising edge of `valid`.
- busy  output  1  high while a conversion is in progress.
- out_valid  output  1  one-cycle strobe; `bcd` and `neg` are newly updated.
- bcd  output  4*DIGITS  packed BCD, most significant digit in the top nibble; held until the next completion.
- neg  output  1  sign of the last converted value (see Optional Feature).
- overrun  output  1  sticky: a result was dropped.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, out_valid, bcd, neg, overrun, pending flag and edge-detect register all 0.
- Edge detect: `valid_d` is `valid` registered every cycle. start = valid & ~valid_d. A continuously high `valid` yields exactly one start.
- States: IDLE, CONV.
  - IDLE: on a start edge, load `answer` into the shift register, clear the BCD accumulator, set iter=0, go to CONV.
  - CONV: each edge, add 3 to every accumulator nibble that is >=5, then shift {acc, sreg} left by 1; iter increments.
  - Completion: on the edge where iter reaches WIDTH-1, the final shifted accumulator is written to `bcd` and `out_valid` is registered high.
- Latency: start sampled at edge E0; `out_valid` is high in the cycle following edge E_WIDTH (E10 for default). Pulse width is exactly 1 cycle.
- busy = (state==CONV). It drops after the completion edge unless pending work exists.
- Pending buffer (1 deep):
  - start while CONV with pend_v=0 (not the completion edge): store `answer` in pend, set pend_v=1.
  - start while CONV with pend_v=1: new value dropped, overrun=1, held until reset.
- Completion edge:
  - If pend_v=1: load pend, clear pend_v, remain CONV (back-to-back). A simultaneous start then goes into pend without overrun.
  - Else if start on the same edge: load `answer` directly and remain CONV.
  - Else: go to IDLE.
- Arithmetic: unsigned; the WIDTH-bit input fits in DIGITS digits; no saturation logic.
- Reset mid-conversion: the conversion is abandoned, no `out_valid`, all outputs 0.

Optional Feature:
- Macro: ANSWER_SIGNED_EN.
- Defined: `answer` is treated as WIDTH-bit two's complement. At load, if the MSB is 1, the two's-complement magnitude is converted and a sign bit is stored. That sign appears on `neg` together with `bcd` at completion. The pending path stores the sign as well.
- Not defined: `answer` is unsigned and `neg` is tied 0.

Test Plan:
- rst low for 2 cycles, release; start with answer=1023, then pull rst low at E5 -> no `out_valid`; bcd=0, busy=0, overrun=0 immediately.
- valid 0->1 with answer=10'd1023 -> out_valid high exactly 1 cycle after E10; bcd=16'h1023; busy high E0..E10 then low.
- answer=0 start -> bcd=16'h0000, out_valid after E10; then answer=10'd509 -> bcd=16'h0509.
- valid held high 6 cycles, answer=42 -> exactly one out_valid, bcd=16'h0042.
- Starts at E0 (7), E3 (300), E5 (999) -> out_valid after E10 with 0007, then after E20 with 0300; 999 dropped, overrun=1 stays 1.
- ANSWER_SIGNED_EN defined, answer=10'h3F6 -> neg=1, bcd=16'h0010. Undefined, same input -> neg=0, bcd=16'h1014.
